// File: rtl/modred_serial_if.sv
// Job/result handshake bundle for the bit-serial modular reducer.
// The slave side is the reducer; the master side is the producer/consumer.
interface modred_serial_if #(
  parameter int W_Q  = 32,
  parameter int W_IN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [W_IN-1:0] in_data;
  logic [W_Q-1:0]  in_q;
  logic            out_valid;
  logic            out_ready;
  logic [W_Q-1:0]  out_data;
  logic            out_err;
  logic            busy;

  modport master (
    output in_valid, in_data, in_q, out_ready,
    input  in_ready, out_valid, out_data, out_err, busy
  );

  modport slave (
    input  in_valid, in_data, in_q, out_ready,
    output in_ready, out_valid, out_data, out_err, busy
  );
endinterface

// File: rtl/modred_serial.sv
// Bit-serial X mod Q: one product bit per cycle, shift-in then conditional subtract.
// Area-minimal reducer placed right after the integer multiplier.
module modred_serial #(
  parameter int W_Q  = 32,
  parameter int W_IN = 64
) (
  input  logic           i_gclk,
  input  logic           i_grst_n,
  modred_serial_if.slave s
);
  localparam int CW = (W_IN > 1) ? $clog2(W_IN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state, w_nxt;
  logic            r_in_ready;
  logic [W_IN-1:0] r_x;
  logic [W_Q-1:0]  r_q, r_r, r_out;
  logic [CW-1:0]   r_cnt;
  logic            r_err;

  logic            w_acc, w_qzero;
  logic [W_Q:0]    w_t, w_diff;
  logic [W_Q-1:0]  w_rn;

  assign w_acc   = (r_state == IDLE) && r_in_ready && s.in_valid;
  assign w_qzero = (s.in_q == '0);

  // R < Q keeps T = 2R+bit below 2Q, so one extra bit covers compare and subtract
  assign w_t    = {r_r, r_x[r_cnt]};
  assign w_diff = w_t - {1'b0, r_q};
  assign w_rn   = (w_t >= {1'b0, r_q}) ? w_diff[W_Q-1:0] : w_t[W_Q-1:0];

  always_ff @(posedge i_gclk or negedge i_grst_n) begin
    if (!i_grst_n) r_state <= IDLE;
    else           r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_nxt = w_qzero ? DONE : RUN;
      RUN:     if (r_cnt == '0) w_nxt = DONE;
      DONE:    if (s.out_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    s.in_ready  = r_in_ready;
    s.out_valid = (r_state == DONE);
    s.busy      = (r_state != IDLE);
    s.out_data  = r_out;
    s.out_err   = r_err;
  end

  // in_ready is its own flop so it stays low through reset and rises one edge later
  always_ff @(posedge i_gclk or negedge i_grst_n) begin
    if (!i_grst_n) begin
      r_in_ready <= 1'b0;
      r_x        <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_cnt      <= '0;
      r_out      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_in_ready <= (w_nxt == IDLE);
      case (r_state)
        IDLE: if (w_acc) begin
          r_x   <= s.in_data;
          r_q   <= s.in_q;
          r_r   <= '0;
          r_cnt <= CW'(W_IN - 1);
          r_err <= w_qzero;
          if (w_qzero) r_out <= '0;
        end
        RUN: begin
          r_r   <= w_rn;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) r_out <= w_rn;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_modred_serial.sv
// Bench for modred_serial: directed 8/16 vectors and corner sequences,
// then random 32/64 jobs against a '%' golden model with throttled out_ready.
module tb_modred_serial;
  logic gclk = 1'b0;
  logic grst_n = 1'b1;
  always #5 gclk = ~gclk;

  modred_serial_if #(.W_Q(8),  .W_IN(16)) a_if ();
  modred_serial_if #(.W_Q(32), .W_IN(64)) b_if ();

  modred_serial #(.W_Q(8),  .W_IN(16)) u_a (.i_gclk(gclk), .i_grst_n(grst_n), .s(a_if.slave));
  modred_serial #(.W_Q(32), .W_IN(64)) u_b (.i_gclk(gclk), .i_grst_n(grst_n), .s(b_if.slave));

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [7:0]  q;
    logic [7:0]  d;
    logic        e;
  } vec_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"},  64'(a_if.in_ready),  64'd0);
    chk({tag, "_out_valid"}, 64'(a_if.out_valid), 64'd0);
    chk({tag, "_out_data"},  64'(a_if.out_data),  64'd0);
    chk({tag, "_out_err"},   64'(a_if.out_err),   64'd0);
    chk({tag, "_busy"},      64'(a_if.busy),      64'd0);
  endtask

  // One job on the 8/16 instance; lat < 0 skips the latency check, hold = cycles of backpressure
  task automatic run_a(input logic [15:0] x, input logic [7:0] q, input logic [7:0] d,
                       input logic e, input int lat, input int hold);
    int   n;
    exp_t ex, got;
    n = 0;
    while (!a_if.in_ready && n < 50) begin @(negedge gclk); n++; end
    chk("a_ready_wait", 64'(a_if.in_ready), 64'd1);
    a_if.in_valid = 1'b1; a_if.in_data = x; a_if.in_q = q;
    ex.d = 32'(d); ex.e = e; sb_a.push_back(ex);
    @(posedge gclk);
    @(negedge gclk);
    a_if.in_valid = 1'b0; a_if.in_data = ~x; a_if.in_q = ~q;
    n = 1;
    chk("a_busy_c1", 64'(a_if.busy), 64'd1);
    chk("a_inrdy_c1", 64'(a_if.in_ready), 64'd0);
    while (!a_if.out_valid && n < 40) begin @(negedge gclk); n++; end
    chk("a_out_valid_seen", 64'(a_if.out_valid), 64'd1);
    if (lat >= 0) chk("a_latency", 64'(n), 64'(lat));
    got = sb_a.pop_front();
    chk("a_out_data", 64'(a_if.out_data), 64'(got.d));
    chk("a_out_err",  64'(a_if.out_err),  64'(got.e));
    for (int h = 0; h < hold; h++) begin
      if (h == 3) begin
        a_if.in_valid = 1'b1; a_if.in_data = 16'h5555; a_if.in_q = 8'h03;
      end
      @(negedge gclk);
      chk("bp_data", 64'(a_if.out_data), 64'(got.d));
      chk("bp_valid", 64'(a_if.out_valid), 64'd1);
      chk("bp_in_ready", 64'(a_if.in_ready), 64'd0);
    end
    a_if.in_valid = 1'b0;
    a_if.out_ready = 1'b1;
    @(negedge gclk);
    a_if.out_ready = 1'b0;
    chk("a_idle_in_ready", 64'(a_if.in_ready), 64'd1);
    chk("a_idle_valid",    64'(a_if.out_valid), 64'd0);
    chk("a_idle_busy",     64'(a_if.busy),      64'd0);
  endtask

  task automatic run_b(input logic [63:0] x, input logic [31:0] q);
    int   n;
    logic got_res, rdy, done;
    exp_t ex, got;
    n = 0;
    while (!b_if.in_ready && n < 50) begin @(negedge gclk); n++; end
    chk("b_ready_wait", 64'(b_if.in_ready), 64'd1);
    b_if.in_valid = 1'b1; b_if.in_data = x; b_if.in_q = q;
    ex.d = 32'(x % {32'd0, q}); ex.e = 1'b0; sb_b.push_back(ex);
    @(posedge gclk);
    @(negedge gclk);
    b_if.in_valid = 1'b0; b_if.in_data = {$urandom, $urandom}; b_if.in_q = $urandom;
    got_res = 1'b0; done = 1'b0; n = 0;
    while (!done && n < 300) begin
      if (b_if.out_valid && !got_res) begin
        got = sb_b.pop_front();
        chk("b_out_data", 64'(b_if.out_data), 64'(got.d));
        chk("b_out_err",  64'(b_if.out_err),  64'(got.e));
        got_res = 1'b1;
      end
      rdy = 1'($urandom_range(0, 1));
      b_if.out_ready = rdy;
      done = b_if.out_valid && rdy;
      @(negedge gclk);
      n++;
    end
    b_if.out_ready = 1'b0;
    if (!done) chk("b_timeout", 64'd0, 64'd1);
  endtask

  vec_t tv[12];

  initial begin
    logic [31:0] ra, rb, rq;

    tv[0]  = '{16'hFFFF, 8'hFB, 8'h18, 1'b0};
    tv[1]  = '{16'h1234, 8'h07, 8'h05, 1'b0};
    tv[2]  = '{16'h00FA, 8'hFB, 8'hFA, 1'b0};
    tv[3]  = '{16'h0000, 8'h35, 8'h00, 1'b0};
    tv[4]  = '{16'hBEEF, 8'h01, 8'h00, 1'b0};
    tv[5]  = '{16'hFFFF, 8'h01, 8'h00, 1'b0};
    tv[6]  = '{16'hABCD, 8'h00, 8'h00, 1'b1};
    tv[7]  = '{16'h0064, 8'h0B, 8'h01, 1'b0};
    tv[8]  = '{16'hFFFF, 8'hFF, 8'h00, 1'b0};
    tv[9]  = '{16'hFFFF, 8'h02, 8'h01, 1'b0};
    tv[10] = '{16'h00FB, 8'hFB, 8'h00, 1'b0};
    tv[11] = '{16'h8001, 8'h80, 8'h01, 1'b0};

    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_q = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_q = '0; b_if.out_ready = 1'b0;

    #1 grst_n = 1'b0;
    #1 chk_reset_outs("rst");
    @(negedge gclk); @(negedge gclk);
    #2 grst_n = 1'b1;
    #1 chk("rst_rel_in_ready_low", 64'(a_if.in_ready), 64'd0);
    @(negedge gclk);
    chk("rst_rel_in_ready_high", 64'(a_if.in_ready), 64'd1);

    for (int i = 0; i < 12; i++)
      run_a(tv[i].x, tv[i].q, tv[i].d, tv[i].e, tv[i].e ? 1 : 17, 0);

    // backpressure: 10 stalled cycles with a stray in_valid, then a fresh job
    run_a(16'h1234, 8'h07, 8'h05, 1'b0, 17, 10);
    run_a(16'h0100, 8'h0D, 8'h09, 1'b0, 17, 0);

    // reset in cycle 5 of RUN aborts the job
    a_if.in_valid = 1'b1; a_if.in_data = 16'hFFFF; a_if.in_q = 8'hFB;
    @(posedge gclk);
    @(negedge gclk);
    a_if.in_valid = 1'b0;
    repeat (4) @(negedge gclk);
    chk("mid_busy", 64'(a_if.busy), 64'd1);
    #2 grst_n = 1'b0;
    #1 chk_reset_outs("mid_rst");
    @(negedge gclk);
    #2 grst_n = 1'b1;
    #1 chk("mid_rel_in_ready_low", 64'(a_if.in_ready), 64'd0);
    @(negedge gclk);
    chk("mid_rel_in_ready_high", 64'(a_if.in_ready), 64'd1);
    run_a(16'h0100, 8'h0D, 8'h09, 1'b0, 17, 0);

    for (int i = 0; i < 300; i++) begin
      rq = (i % 4 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (rq == 0) rq = 32'd1;
      run_b({$urandom, $urandom}, rq);
    end
    for (int i = 0; i < 20; i++) run_b({$urandom, $urandom}, 32'hFFFF_FFFF);
    run_b(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
    run_b(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFB);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rq = $urandom | 32'h1;
      run_b(64'(ra) * 64'(rb), rq);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
